// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the CPU memory-port arbiter.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_t;

    localparam logic MEM_RW_READ  = 1'b0;
    localparam logic MEM_RW_WRITE = 1'b1;

    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ_DATA) ? REQ_FETCH : REQ_DATA;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM pin bundle for mem_port_arbiter; slave = arbiter view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_gnt;
    logic              fetch_rvalid;
    logic [DATA_W-1:0] fetch_rdata;

    logic              data_req;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_gnt;
    logic              data_rvalid;
    logic [DATA_W-1:0] data_rdata;

    logic              mem_en;
    logic              mem_rw;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  fetch_req, fetch_addr,
        input  data_req, data_we, data_addr, data_wdata,
        input  mem_rdata,
        output fetch_gnt, fetch_rvalid, fetch_rdata,
        output data_gnt, data_rvalid, data_rdata,
        output mem_en, mem_rw, mem_addr, mem_wdata
    );

    modport master (
        output fetch_req, fetch_addr,
        output data_req, data_we, data_addr, data_wdata,
        output mem_rdata,
        input  fetch_gnt, fetch_rvalid, fetch_rdata,
        input  data_gnt, data_rvalid, data_rdata,
        input  mem_en, mem_rw, mem_addr, mem_wdata
    );

endinterface

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner select between fetch and data requests.
module mem_arb_pick
    import cpu_mem_pkg::*;
(
    input  logic    i_fetch_req,
    input  logic    i_data_req,
    input  req_id_t i_last_gnt,
    output logic    o_any_req,
    output req_id_t o_winner
);

    // With i_last_gnt tied to REQ_FETCH this reduces to data-over-fetch priority.
    always_comb begin
        o_any_req = i_fetch_req | i_data_req;
        o_winner  = REQ_DATA;
        if (i_fetch_req && i_data_req) begin
            o_winner = other_req(i_last_gnt);
        end else if (i_fetch_req) begin
            o_winner = REQ_FETCH;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-ported RAM between fetch and load/store requesters.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin; default is data-over-fetch priority.
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    arb_state_t        r_state;
    arb_state_t        w_next;
    req_id_t           r_owner;
    logic              r_rw;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_fetch_rdata;
    logic [DATA_W-1:0] r_data_rdata;

    logic              w_any_req;
    logic              w_arb;
    req_id_t           w_winner;
    req_id_t           w_last;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    req_id_t r_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last <= REQ_FETCH;
        end else if (w_arb) begin
            r_last <= w_winner;
        end
    end

    assign w_last = r_last;
`else
    assign w_last = REQ_FETCH;
`endif

    mem_arb_pick u_pick (
        .i_fetch_req (bus.fetch_req),
        .i_data_req  (bus.data_req),
        .i_last_gnt  (w_last),
        .o_any_req   (w_any_req),
        .o_winner    (w_winner)
    );

    assign w_arb = ((r_state == IDLE) || (r_state == RESP)) && w_any_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner <= REQ_FETCH;
            r_rw    <= MEM_RW_READ;
            r_addr  <= '0;
            r_wdata <= '0;
        end else if (w_arb) begin
            r_owner <= w_winner;
            if (w_winner == REQ_DATA) begin
                r_rw    <= bus.data_we ? MEM_RW_WRITE : MEM_RW_READ;
                r_addr  <= bus.data_addr;
                r_wdata <= bus.data_wdata;
            end else begin
                r_rw    <= MEM_RW_READ;
                r_addr  <= bus.fetch_addr;
                r_wdata <= '0;
            end
        end
    end

    // RAM read data is only valid while mem_en is high, so capture at the end of ACCESS.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_rdata <= '0;
            r_data_rdata  <= '0;
        end else if ((r_state == ACCESS) && (r_rw == MEM_RW_READ)) begin
            if (r_owner == REQ_FETCH) begin
                r_fetch_rdata <= bus.mem_rdata;
            end else begin
                r_data_rdata <= bus.mem_rdata;
            end
        end
    end

    always_comb begin
        w_next           = r_state;
        bus.fetch_gnt    = 1'b0;
        bus.data_gnt     = 1'b0;
        bus.fetch_rvalid = 1'b0;
        bus.data_rvalid  = 1'b0;
        bus.mem_en       = 1'b0;
        bus.mem_rw       = MEM_RW_READ;
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        case (r_state)
            IDLE, RESP: begin
                w_next = w_any_req ? ACCESS : IDLE;
                if ((r_state == RESP) && (r_rw == MEM_RW_READ)) begin
                    bus.fetch_rvalid = (r_owner == REQ_FETCH);
                    bus.data_rvalid  = (r_owner == REQ_DATA);
                end
            end
            ACCESS: begin
                w_next        = RESP;
                bus.mem_en    = 1'b1;
                bus.mem_rw    = r_rw;
                bus.mem_addr  = r_addr;
                bus.mem_wdata = r_wdata;
                bus.fetch_gnt = (r_owner == REQ_FETCH);
                bus.data_gnt  = (r_owner == REQ_DATA);
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign bus.fetch_rdata = r_fetch_rdata;
    assign bus.data_rdata  = r_data_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a grant/read-data scoreboard.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;

    mem_port_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Small RAM behind the arbiter: combinational read, write at the clock edge.
    logic [31:0] ram [0:255];
    assign bus.mem_rdata = bus.mem_en ? ram[bus.mem_addr[7:0]] : 32'h0;
    always @(posedge clk) begin
        if (bus.mem_en && bus.mem_rw) ram[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end

    typedef struct {
        bit          owner;
        logic [31:0] data;
    } rd_t;

    bit          gnt_q [$];
    rd_t         rd_q  [$];
    logic [31:0] model [int];
    int          total = 0;
    int          bad   = 0;

    function automatic logic [31:0] model_rd(input int a);
        return model.exists(a) ? model[a] : 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every grant and every rvalid must match the next queued expectation.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.fetch_gnt || bus.data_gnt) begin
                chk("gnt_onehot", 64'(bus.fetch_gnt & bus.data_gnt), 64'd0);
                chk("gnt_expected", 64'(gnt_q.size() > 0), 64'd1);
                if (gnt_q.size() > 0) chk("gnt_owner", 64'(bus.data_gnt), 64'(gnt_q.pop_front()));
            end
            if (bus.fetch_rvalid || bus.data_rvalid) begin
                chk("rvalid_expected", 64'(rd_q.size() > 0), 64'd1);
                if (rd_q.size() > 0) begin
                    rd_t r;
                    r = rd_q.pop_front();
                    chk("rvalid_owner", 64'(bus.data_rvalid), 64'(r.owner));
                    chk("rdata", bus.data_rvalid ? 64'(bus.data_rdata) : 64'(bus.fetch_rdata), 64'(r.data));
                end
            end
        end
    end

    task automatic access(input bit own, input bit we, input logic [15:0] a, input logic [31:0] wd);
        bit got;
        got = 1'b0;
        @(negedge clk);
        if (own) begin
            bus.data_req = 1'b1; bus.data_we = we; bus.data_addr = a; bus.data_wdata = wd;
        end else begin
            bus.fetch_req = 1'b1; bus.fetch_addr = a;
        end
        gnt_q.push_back(own);
        if (!we) rd_q.push_back('{own, model_rd(int'(a))});
        else     model[int'(a)] = wd;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            got = own ? bus.data_gnt : bus.fetch_gnt;
        end
        chk("access_gnt_seen", 64'(got), 64'd1);
        bus.data_req  = 1'b0;
        bus.fetch_req = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ctl"}, {58'd0, bus.fetch_gnt, bus.data_gnt, bus.fetch_rvalid,
                            bus.data_rvalid, bus.mem_en, bus.mem_rw}, 64'd0);
        chk({tag, "_addr"},  64'(bus.mem_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(bus.mem_wdata), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t limit=200000", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, nf, last_cyc, nd_t, nf_t;
        reset          = 1'b1;
        bus.fetch_req  = 1'b0; bus.fetch_addr = '0;
        bus.data_req   = 1'b0; bus.data_we = 1'b0; bus.data_addr = '0; bus.data_wdata = '0;

        // Reset state
        #1;
        chk_all_zero("reset");
        chk("reset_fetch_rdata", 64'(bus.fetch_rdata), 64'd0);
        chk("reset_data_rdata",  64'(bus.data_rdata),  64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_all_zero("idle");

        // Preload through the data port
        access(1'b1, 1'b1, 16'h0004, 32'hA1B2C3D4);
        access(1'b1, 1'b1, 16'h0020, 32'h1111_1111);

        // Single fetch with cycle-exact checks
        @(negedge clk);
        bus.fetch_req = 1'b1; bus.fetch_addr = 16'h0004;
        gnt_q.push_back(1'b0);
        rd_q.push_back('{1'b0, 32'hA1B2C3D4});
        @(posedge clk); #1;
        chk("fetch_c1_gnt",   64'(bus.fetch_gnt), 64'd1);
        chk("fetch_c1_en",    64'(bus.mem_en),    64'd1);
        chk("fetch_c1_rw",    64'(bus.mem_rw),    64'd0);
        chk("fetch_c1_addr",  64'(bus.mem_addr),  64'h4);
        chk("fetch_c1_dgnt",  64'(bus.data_gnt),  64'd0);
        bus.fetch_req = 1'b0;
        @(posedge clk); #1;
        chk("fetch_c2_rvalid", 64'(bus.fetch_rvalid), 64'd1);
        chk("fetch_c2_rdata",  64'(bus.fetch_rdata),  64'hA1B2C3D4);
        chk("fetch_c2_en",     64'(bus.mem_en),       64'd0);
        chk("fetch_c2_addr",   64'(bus.mem_addr),     64'd0);
        @(posedge clk); #1;
        chk("fetch_c3_rvalid", 64'(bus.fetch_rvalid), 64'd0);
        chk("fetch_c3_rdata_hold", 64'(bus.fetch_rdata), 64'hA1B2C3D4);

        // Store then load
        @(negedge clk);
        bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_addr = 16'h0010; bus.data_wdata = 32'h0000_002A;
        gnt_q.push_back(1'b1);
        model[16'h0010] = 32'h0000_002A;
        @(posedge clk); #1;
        chk("store_gnt",   64'(bus.data_gnt),  64'd1);
        chk("store_rw",    64'(bus.mem_rw),    64'd1);
        chk("store_addr",  64'(bus.mem_addr),  64'h10);
        chk("store_wdata", 64'(bus.mem_wdata), 64'h2A);
        bus.data_req = 1'b0;
        @(posedge clk); #1;
        chk("store_no_rvalid", 64'(bus.data_rvalid), 64'd0);
        access(1'b1, 1'b0, 16'h0010, 32'h0);
        chk("load_rdata_hold", 64'(bus.data_rdata), 64'h2A);
        chk("fetch_rdata_untouched", 64'(bus.fetch_rdata), 64'hA1B2C3D4);

        // Simultaneous requests held
`ifdef MEM_ARB_ROUND_ROBIN_EN
        nd_t = 2; nf_t = 2;
        gnt_q.push_back(1'b1); rd_q.push_back('{1'b1, 32'h2A});
        gnt_q.push_back(1'b0); rd_q.push_back('{1'b0, 32'hA1B2C3D4});
        gnt_q.push_back(1'b1); rd_q.push_back('{1'b1, 32'h2A});
        gnt_q.push_back(1'b0); rd_q.push_back('{1'b0, 32'hA1B2C3D4});
`else
        nd_t = 3; nf_t = 1;
        repeat (3) begin
            gnt_q.push_back(1'b1); rd_q.push_back('{1'b1, 32'h2A});
        end
        gnt_q.push_back(1'b0); rd_q.push_back('{1'b0, 32'hA1B2C3D4});
`endif
        nd = 0; nf = 0; last_cyc = -1;
        @(negedge clk);
        bus.data_req  = 1'b1; bus.data_we = 1'b0; bus.data_addr = 16'h0010;
        bus.fetch_req = 1'b1; bus.fetch_addr = 16'h0004;
        for (int i = 0; i < 40 && !(nd == nd_t && nf == nf_t); i++) begin
            @(posedge clk); #1;
            if (bus.data_gnt || bus.fetch_gnt) begin
                if (last_cyc >= 0) chk("sim_gnt_spacing", 64'(i - last_cyc), 64'd2);
                last_cyc = i;
            end
            if (bus.data_gnt) begin
                nd++;
                if (nd == nd_t) bus.data_req = 1'b0;
            end
            if (bus.fetch_gnt) begin
                nf++;
                if (nf == nf_t) bus.fetch_req = 1'b0;
            end
        end
        bus.data_req = 1'b0; bus.fetch_req = 1'b0;
        chk("sim_data_gnts",  64'(nd), 64'(nd_t));
        chk("sim_fetch_gnts", 64'(nf), 64'(nf_t));
        repeat (2) @(posedge clk);

        // Reset during the ACCESS cycle of a store
        @(negedge clk);
        bus.data_req = 1'b1; bus.data_we = 1'b1; bus.data_addr = 16'h0020; bus.data_wdata = 32'h0000_0055;
        @(posedge clk); #1;
        chk("rst_access_en", 64'(bus.mem_en), 64'd1);
        #1 reset = 1'b1;
        #1;
        chk_all_zero("rst_async");
        bus.data_req = 1'b0; bus.data_we = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_fetch_rdata", 64'(bus.fetch_rdata), 64'd0);
        chk("rst_data_rdata",  64'(bus.data_rdata),  64'd0);
        @(posedge clk); #1;
        chk_all_zero("rst_idle");
        // Interrupted store must not have reached RAM
        access(1'b1, 1'b0, 16'h0020, 32'h0);
        access(1'b0, 1'b0, 16'h0004, 32'h0);

        repeat (3) @(posedge clk);
        chk("gnt_q_drained", 64'(gnt_q.size()), 64'd0);
        chk("rd_q_drained",  64'(rd_q.size()),  64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
